// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between an instruction-cache refill port and
// a data-cache refill/write port, sharing one single-outstanding memory channel.
// Refills fetch LINE_WORDS consecutive words; writes move a single word.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    // instruction cache (refill only)
    input  logic                    i_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_req_ready,
    output logic                    i_resp_valid,
    output logic [DATA_WIDTH-1:0]   i_resp_data,
    output logic                    i_resp_last,

    // data cache (refill or single-word write)
    input  logic                    d_req_valid,
    input  logic                    d_req_write,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_req_ready,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic                    d_resp_last,

    // memory channel
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int WORD_OFF_W = $clog2(STRB_W);
    localparam int LINE_OFF_W = $clog2(LINE_WORDS * STRB_W);
    localparam int BEAT_W     = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BEAT_W-1:0]       r_beat;
    logic                    r_last_grant_d;   // 1: dcache was granted most recently
    logic                    r_grant_d;        // owner of the current transaction
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;

    logic                    w_grant_i;
    logic                    w_grant_d;
    logic                    w_cap_write;
    logic [ADDR_WIDTH-1:0]   w_cap_addr;
    logic [ADDR_WIDTH-1:0]   w_cap_base;
    logic                    w_resp_fire;
    logic                    w_resp_final;
    logic                    w_issue;

    // Clear the low off_w address bits (word or line alignment).
    function automatic logic [ADDR_WIDTH-1:0] f_align(input logic [ADDR_WIDTH-1:0] addr,
                                                      input int off_w);
        logic [ADDR_WIDTH-1:0] mask;
        mask = {ADDR_WIDTH{1'b1}} << off_w;
        return addr & mask;
    endfunction

    // Byte offset of a beat within the line.
    function automatic logic [ADDR_WIDTH-1:0] f_beat_offset(input logic [BEAT_W-1:0] beat);
        return ADDR_WIDTH'(beat) << WORD_OFF_W;
    endfunction

    // Round-robin grant, only offered while idle and out of reset.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!rst && (r_state == ST_IDLE)) begin
            if (i_req_valid && d_req_valid) begin
                w_grant_i = r_last_grant_d;
                w_grant_d = !r_last_grant_d;
            end else begin
                w_grant_i = i_req_valid;
                w_grant_d = d_req_valid;
            end
        end else begin
            w_grant_i = 1'b0;
            w_grant_d = 1'b0;
        end
    end

    // Payload to capture on a grant; write targets a word, refill a whole line.
    always_comb begin
        w_cap_write = w_grant_d & d_req_write;
        w_cap_addr  = w_grant_d ? d_req_addr : i_req_addr;
        if (w_cap_write) begin
            w_cap_base = f_align(w_cap_addr, WORD_OFF_W);
        end else begin
            w_cap_base = f_align(w_cap_addr, LINE_OFF_W);
        end
    end

    // Memory-side event decode.
    always_comb begin
        w_issue      = !rst && (r_state == ST_ISSUE);
        w_resp_fire  = !rst && (r_state == ST_WAIT) && mem_resp_valid;
        w_resp_final = r_write || (r_beat == LAST_BEAT);
    end

    // Next-state logic; ready/resp outside their own state are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = w_resp_final ? ST_IDLE : ST_ISSUE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter: restarts on each grant, advances per response, wraps at completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_grant_i || w_grant_d) begin
            r_beat <= '0;
        end else if (w_resp_fire) begin
            r_beat <= w_resp_final ? '0 : (r_beat + BEAT_W'(1));
        end else begin
            r_beat <= r_beat;
        end
    end

    // Round-robin history and captured request payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant_d <= 1'b1;
            r_grant_d      <= 1'b0;
            r_write        <= 1'b0;
            r_base         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
        end else if (w_grant_i || w_grant_d) begin
            r_last_grant_d <= w_grant_d;
            r_grant_d      <= w_grant_d;
            r_write        <= w_cap_write;
            r_base         <= w_cap_base;
            r_wdata        <= w_cap_write ? d_req_wdata : '0;
            r_wstrb        <= w_cap_write ? d_req_wstrb : '0;
        end else begin
            r_last_grant_d <= r_last_grant_d;
            r_grant_d      <= r_grant_d;
            r_write        <= r_write;
            r_base         <= r_base;
            r_wdata        <= r_wdata;
            r_wstrb        <= r_wstrb;
        end
    end

    // Requester handshakes and the memory request, all forced low during reset.
    always_comb begin
        i_req_ready   = w_grant_i;
        d_req_ready   = w_grant_d;
        mem_req_valid = w_issue;
        if (w_issue) begin
            mem_req_write = r_write;
            mem_req_addr  = r_base + f_beat_offset(r_beat);
            mem_req_wdata = r_wdata;
            mem_req_wstrb = r_wstrb;
        end else begin
            mem_req_write = 1'b0;
            mem_req_addr  = '0;
            mem_req_wdata = '0;
            mem_req_wstrb = '0;
        end
    end

    // Response steering: memory data passes straight through to the owner.
    always_comb begin
        i_resp_valid = w_resp_fire && !r_grant_d;
        d_resp_valid = w_resp_fire && r_grant_d;
        i_resp_last  = i_resp_valid && w_resp_final;
        d_resp_last  = d_resp_valid && w_resp_final;
        if (i_resp_valid) begin
            i_resp_data = mem_resp_data;
        end else begin
            i_resp_data = '0;
        end
        if (d_resp_valid) begin
            d_resp_data = mem_resp_data;
        end else begin
            d_resp_data = '0;
        end
    end

endmodule
